// File: rtl/code_stream_decoder.sv
// code_stream_decoder
// Receive side of the byte-code mapping path. Accepted 8-bit codes are decoded
// into a 4-bit payload nibble plus an error flag and buffered in a small FIFO.
// Error beats are counted (saturating) and, optionally, halt intake until a
// clr_err pulse.
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   in_valid/ready  input handshake, in_code is the encoded byte
//   out_valid/ready output handshake, out_data/out_err show the FIFO head
//   clr_err         synchronous pulse: clear error state and resume intake
//   err_sticky      set by any accepted error beat
//   err_count       saturating count of accepted error beats
//   halted          intake stopped after an error beat
module code_stream_decoder #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned ERR_CNT_W   = 8,
  parameter int unsigned HALT_ON_ERR = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_code,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [3:0]           out_data,
  output logic                 out_err,
  input  logic                 clr_err,
  output logic                 err_sticky,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic                 halted
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PtrW:0] DepthCnt = (PtrW + 1)'(DEPTH);

  typedef enum logic [0:0] {StRun, StHalt} state_t;

  state_t          state;
  logic [4:0]      mem [DEPTH];  // {data, err}
  logic [PtrW-1:0] wr_ptr;
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW:0]   count;

  logic       full;
  logic       push;
  logic       pop;
  logic       dec_err;
  logic [3:0] dec_data;
  logic       err_inc;

  // Only 0x00-0x0F carry payload; everything else (incl. fallback 0xFF) is an error.
  always_comb begin
    dec_err  = |in_code[7:4];
    dec_data = dec_err ? 4'h0 : in_code[3:0];
  end

  always_comb begin
    full      = (count == DepthCnt);
    in_ready  = (state == StRun) && !full;
    out_valid = (count != '0);
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
    err_inc   = push && dec_err;
    out_data  = out_valid ? mem[rd_ptr][4:1] : 4'h0;
    out_err   = out_valid ? mem[rd_ptr][0] : 1'b0;
  end

  // Storage needs no reset: out_valid masks any stale entry.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {dec_data, dec_err};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // An error beat accepted together with clr_err wins: count restarts at 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end else if (err_inc) begin
      err_sticky <= 1'b1;
      if (clr_err) begin
        err_count <= ERR_CNT_W'(1);
      end else if (!(&err_count)) begin
        err_count <= err_count + 1'b1;
      end
    end else if (clr_err) begin
      err_sticky <= 1'b0;
      err_count  <= '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= StRun;
      halted <= 1'b0;
    end else begin
      unique case (state)
        StRun: begin
          if (err_inc && (HALT_ON_ERR != 0)) begin
            state  <= StHalt;
            halted <= 1'b1;
          end
        end
        StHalt: begin
          if (clr_err) begin
            state  <= StRun;
            halted <= 1'b0;
          end
        end
        default: begin
          state  <= StRun;
          halted <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_code_stream_decoder.sv
// Bench for code_stream_decoder. Three instances: 0 halts on error (8-bit
// counter), 1 keeps running (8-bit counter), 2 keeps running with a 2-bit
// counter. One instance is exercised at a time (sel); the others stay idle.
module tb_code_stream_decoder;

  logic       clk;
  logic       rst;
  logic       in_valid   [3];
  logic [7:0] in_code    [3];
  logic       out_ready  [3];
  logic       clr_err    [3];
  logic       in_ready   [3];
  logic       out_valid  [3];
  logic [3:0] out_data   [3];
  logic       out_err    [3];
  logic       err_sticky [3];
  logic       halted     [3];
  logic [7:0] err_count0;
  logic [7:0] err_count1;
  logic [1:0] err_count2;

  int checks = 0;
  int errors = 0;
  int sel    = 0;
  logic [4:0] sbq [$];

  typedef struct {
    logic [7:0] code;
    logic [3:0] data;
    logic       err;
  } vec_t;

  code_stream_decoder #(.DEPTH(4), .ERR_CNT_W(8), .HALT_ON_ERR(1)) dut_h (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_code(in_code[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_err(out_err[0]), .clr_err(clr_err[0]),
    .err_sticky(err_sticky[0]), .err_count(err_count0), .halted(halted[0])
  );

  code_stream_decoder #(.DEPTH(4), .ERR_CNT_W(8), .HALT_ON_ERR(0)) dut_r (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_code(in_code[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_err(out_err[1]), .clr_err(clr_err[1]),
    .err_sticky(err_sticky[1]), .err_count(err_count1), .halted(halted[1])
  );

  code_stream_decoder #(.DEPTH(4), .ERR_CNT_W(2), .HALT_ON_ERR(0)) dut_s (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .in_code(in_code[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .out_data(out_data[2]), .out_err(out_err[2]), .clr_err(clr_err[2]),
    .err_sticky(err_sticky[2]), .err_count(err_count2), .halted(halted[2])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, required finish before 200000");
    $fatal(1);
  end

  function automatic logic [7:0] cnt_of(int k);
    case (k)
      0:       return err_count0;
      1:       return err_count1;
      default: return {6'b0, err_count2};
    endcase
  endfunction

  // Reference decode: {data, err}.
  function automatic logic [4:0] dec(logic [7:0] c);
    if (c <= 8'h0F) return {c[3:0], 1'b0};
    return 5'b0000_1;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s (dut %0d): got %0h, expected %0h at %0t", name, sel, act, exp, $time);
    end
  endtask

  // One clock cycle with scoreboard bookkeeping, sampled at the falling edge.
  task automatic tick();
    logic [4:0] exp;
    @(negedge clk);
    chk("out_valid", 32'(out_valid[sel]), 32'(sbq.size() != 0));
    if (!out_valid[sel]) chk("idle_zero", 32'({out_data[sel], out_err[sel]}), 32'h0);
    if (out_valid[sel] && out_ready[sel]) begin
      if (sbq.size() == 0) begin
        chk("unexpected_pop", 32'(1), 32'(0));
      end else begin
        exp = sbq.pop_front();
        chk("head", 32'({out_data[sel], out_err[sel]}), 32'(exp));
      end
    end
    if (in_valid[sel] && in_ready[sel]) sbq.push_back(dec(in_code[sel]));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid[k] = 1'b0; in_code[k] = 8'h00; out_ready[k] = 1'b0; clr_err[k] = 1'b0;
    end
    sbq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vec_t vt [8];
    vt[0] = '{8'h00, 4'h0, 1'b0};
    vt[1] = '{8'h07, 4'h7, 1'b0};
    vt[2] = '{8'h0F, 4'hF, 1'b0};
    vt[3] = '{8'h10, 4'h0, 1'b1};
    vt[4] = '{8'h80, 4'h0, 1'b1};
    vt[5] = '{8'hFE, 4'h0, 1'b1};
    vt[6] = '{8'hFF, 4'h0, 1'b1};
    vt[7] = '{8'h0A, 4'hA, 1'b0};

    // Reset state and basic pass-through on the halting instance.
    sel = 0;
    do_reset();
    chk("rst_in_ready", 32'(in_ready[0]), 32'(1));
    chk("rst_out_valid", 32'(out_valid[0]), 32'(0));
    chk("rst_err_count", 32'(cnt_of(0)), 32'(0));
    chk("rst_sticky", 32'(err_sticky[0]), 32'(0));
    chk("rst_halted", 32'(halted[0]), 32'(0));
    out_ready[0] = 1'b1;
    in_valid[0]  = 1'b1;
    in_code[0] = 8'h03; tick();
    in_code[0] = 8'h0A; tick();
    in_code[0] = 8'h0F; tick();
    in_valid[0] = 1'b0;
    repeat (3) tick();
    chk("basic_err_count", 32'(cnt_of(0)), 32'(0));

    // Fill with out_ready low: exactly four beats accepted.
    do_reset();
    in_valid[0] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("fill_in_ready", 32'(in_ready[0]), 32'(i < 4));
      in_code[0] = 8'(i);
      tick();
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    chk("full_in_ready", 32'(in_ready[0]), 32'(0));
    tick();
    chk("after_pop_in_ready", 32'(in_ready[0]), 32'(1));
    repeat (4) tick();

    // Halt on error, drain, clear, resume.
    do_reset();
    in_valid[0] = 1'b1;
    in_code[0] = 8'h05; tick();
    in_code[0] = 8'hFF; tick();
    chk("halt_halted", 32'(halted[0]), 32'(1));
    chk("halt_in_ready", 32'(in_ready[0]), 32'(0));
    chk("halt_err_count", 32'(cnt_of(0)), 32'(1));
    chk("halt_sticky", 32'(err_sticky[0]), 32'(1));
    in_code[0] = 8'h06;
    repeat (2) tick();
    out_ready[0] = 1'b1;
    repeat (2) tick();
    chk("halt_drained_halted", 32'(halted[0]), 32'(1));
    clr_err[0] = 1'b1; tick();
    clr_err[0] = 1'b0;
    chk("clr_halted", 32'(halted[0]), 32'(0));
    chk("clr_err_count", 32'(cnt_of(0)), 32'(0));
    chk("clr_sticky", 32'(err_sticky[0]), 32'(0));
    chk("clr_in_ready", 32'(in_ready[0]), 32'(1));
    tick();
    in_valid[0] = 1'b0;
    repeat (2) tick();

    // Decode table on the non-halting instance.
    sel = 1;
    do_reset();
    foreach (vt[i]) begin
      in_valid[1] = 1'b1;
      in_code[1]  = vt[i].code;
      tick();
      in_valid[1] = 1'b0;
      chk("tbl_valid", 32'(out_valid[1]), 32'(1));
      chk("tbl_data", 32'(out_data[1]), 32'(vt[i].data));
      chk("tbl_err", 32'(out_err[1]), 32'(vt[i].err));
      out_ready[1] = 1'b1;
      tick();
      out_ready[1] = 1'b0;
    end
    chk("tbl_err_count", 32'(cnt_of(1)), 32'(4));

    // No halt with HALT_ON_ERR=0.
    do_reset();
    out_ready[1] = 1'b1;
    in_valid[1]  = 1'b1;
    in_code[1] = 8'h10; tick();
    in_code[1] = 8'h80; tick();
    in_code[1] = 8'hFF; tick();
    chk("run_in_ready", 32'(in_ready[1]), 32'(1));
    in_code[1] = 8'h02; tick();
    in_valid[1] = 1'b0;
    repeat (3) tick();
    chk("run_halted", 32'(halted[1]), 32'(0));
    chk("run_err_count", 32'(cnt_of(1)), 32'(3));
    chk("run_sticky", 32'(err_sticky[1]), 32'(1));

    // Counter saturation, then clr_err coinciding with an error beat.
    sel = 2;
    do_reset();
    out_ready[2] = 1'b1;
    in_valid[2]  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_code[2] = 8'h20 + 8'(i);
      tick();
    end
    chk("sat_err_count", 32'(cnt_of(2)), 32'(3));
    in_code[2] = 8'h99;
    clr_err[2] = 1'b1;
    tick();
    clr_err[2]  = 1'b0;
    in_valid[2] = 1'b0;
    chk("clr_vs_err_count", 32'(cnt_of(2)), 32'(1));
    chk("clr_vs_err_sticky", 32'(err_sticky[2]), 32'(1));
    repeat (3) tick();

    // Asynchronous reset with three buffered beats and a pending input.
    sel = 1;
    do_reset();
    in_valid[1] = 1'b1;
    in_code[1] = 8'h01; tick();
    in_code[1] = 8'hEE; tick();
    in_code[1] = 8'h02; tick();
    in_code[1] = 8'h09;
    #3;
    rst = 1'b0;
    #1;
    chk("arst_out_valid", 32'(out_valid[1]), 32'(0));
    chk("arst_out", 32'({out_data[1], out_err[1]}), 32'(0));
    chk("arst_err_count", 32'(cnt_of(1)), 32'(0));
    chk("arst_sticky", 32'(err_sticky[1]), 32'(0));
    chk("arst_in_ready", 32'(in_ready[1]), 32'(1));
    in_valid[1] = 1'b0;
    sbq.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("arst_rel_in_ready", 32'(in_ready[1]), 32'(1));
    out_ready[1] = 1'b1;
    repeat (3) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/code_stream_decoder.md
Name: code_stream_decoder

Overview:
- Receive side of the byte-code mapping path: takes 8-bit codes produced by the code mapper and recovers the 4-bit payload nibble.
- Flags fallback/invalid codes, counts them, and optionally halts intake on the first error.
- Decoded beats are buffered in a small FIFO with valid/ready handshakes on both sides.
- Sits between the mapper output register and downstream nibble consumers.

Parameters:
- DEPTH, 4, FIFO depth in entries; power of two, >= 2.
- ERR_CNT_W, 8, width of the saturating error counter.
- HALT_ON_ERR, 1, 1 = stop accepting input after an error beat until cleared; 0 = keep running.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_code is valid.
- in_ready  output  1  decoder can accept a code this cycle.
- in_code  input  8  encoded byte.
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer accepts the head this cycle.
- out_data  output  4  decoded nibble at FIFO head.
- out_err  output  1  FIFO head beat is an error beat.
- clr_err  input  1  synchronous pulse: clears error state and resumes intake.
- err_sticky  output  1  set on any accepted error beat.
- err_count  output  ERR_CNT_W  number of accepted error beats, saturating.
- halted  output  1  state is HALT.

Behaviour:
- Reset (rst low, asynchronous):
  - FIFO empty, pointers 0, state RUN.
  - out_valid=0, out_data=0, out_err=0, err_sticky=0, err_count=0, halted=0.
  - in_ready=1 while in reset and on the first cycle after release.
  - Reset mid-transfer discards all buffered beats.
- Decode table (combinational, applied at acceptance):
  - Codes 0x00–0x0F: data = code[3:0], err=0.
  - Code 0xFF (mapper fallback): data=0, err=1.
  - Any other code: data=0, err=1.
- Input handshake:
  - in_ready = (state==RUN) && !full.
  - A beat is accepted on a rising edge with in_valid && in_ready.
  - The decoded {data, err} is written to the FIFO tail at that edge.
- Output handshake:
  - out_valid = (count != 0).
  - out_data and out_err show the head entry and are forced to 0 when out_valid=0.
  - The head pops on a rising edge with out_valid && out_ready.
- Latency: a beat accepted into an empty FIFO at edge N gives out_valid=1 in the cycle after N. There is no same-cycle bypass.
- Push and pop in the same cycle:
  - Count unchanged, both pointers advance.
  - When full, in_ready=0 even if out_ready=1.
  - Pointers wrap modulo DEPTH.
- States:
  - RUN -> HALT when an error beat is accepted and HALT_ON_ERR=1. The error beat is still written.
  - HALT: in_ready=0, halted=1, FIFO keeps draining normally.
  - HALT -> RUN on clr_err=1; in_ready may rise the next cycle.
  - With HALT_ON_ERR=0 the block never leaves RUN.
- Error accounting:
  - Each accepted error beat sets err_sticky and increments err_count.
  - err_count saturates at all-ones and never wraps.
  - clr_err clears err_sticky and err_count to 0.
  - clr_err in the same cycle as an accepted error beat: the error wins. Result is err_count=1, err_sticky=1, and HALT if HALT_ON_ERR=1.
- clr_err never flushes FIFO contents.

Test Plan:
- Reset, then push codes 0x03, 0x0A, 0x0F with out_ready=1 -> out_data 3, A, F on consecutive cycles, each one cycle after acceptance. out_err=0, err_count=0.
- out_ready=0, push valid codes continuously -> exactly DEPTH (4) beats accepted, then in_ready=0. Raise out_ready -> beats drain in order and in_ready returns the cycle after the first pop.
- HALT_ON_ERR=1: push 0x05, 0xFF, 0x06 -> 0x05 and 0xFF accepted; halted=1, in_ready=0, 0x06 held off. Drained outputs: (5,0), (0,1). err_count=1, err_sticky=1. Pulse clr_err -> halted=0, count 0, 0x06 accepted next.
- HALT_ON_ERR=0: push 0x10, 0x80, 0xFF, 0x02 -> all accepted, no halt. err_count=3, outputs (0,1)x3 then (2,0).
- HALT_ON_ERR=0, ERR_CNT_W=2: push 5 error codes -> err_count saturates at 3. clr_err together with a sixth error beat -> err_count=1.
- Assert rst while the FIFO holds 3 beats and an input beat is pending -> all outputs return to reset values immediately. After release: FIFO empty, in_ready=1, no stale beat appears.
